// File: rtl/dff_var.sv
// rtl/dff_var.sv - WIDTH-bit load-enable register with asynchronous active-low clear
// Each bit is a hold/load mux2_1 feeding a D flop; mux2_1 is defined here too.
`timescale 1ns/10ps

module mux2_1 (
  input  logic i0,
  input  logic i1,
  input  logic sel,
  output logic out
);

  // Ternary merge keeps out known when sel is X but i0 == i1.
  assign out = sel ? i1 : i0;

endmodule

module dff_var #(
  parameter int               WIDTH     = 64,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic bit_d;
    logic bit_q;

    mux2_1 u_mux (
      .i0  (bit_q),
      .i1  (d[i]),
      .sel (en),
      .out (bit_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        bit_q <= RESET_VAL[i];
      end else begin
        bit_q <= bit_d;
      end
    end

    assign q[i] = bit_q;
  end

endmodule

// File: tb/tb_dff_var.sv
// tb/tb_dff_var.sv - scoreboard bench for dff_var at WIDTH 64, 1 and 5 plus mux2_1 truth table
`timescale 1ns/10ps

module tb_dff_var;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [63:0] d;
  logic [63:0] q64;
  logic [0:0]  q1;
  logic [4:0]  q5;
  logic        mi0, mi1, msel, mout;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp64_q[$];
  logic [0:0]  exp1_q[$];
  logic [4:0]  exp5_q[$];

  // Reference register contents, updated once per issued clock cycle.
  logic [63:0] m64;
  logic [0:0]  m1;
  logic [4:0]  m5;

  always #5 clk = ~clk;

  dff_var #(.WIDTH(64)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d), .q(q64)
  );

  dff_var #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d[0:0]), .q(q1)
  );

  dff_var #(.WIDTH(5), .RESET_VAL(5'h15)) u_dut5 (
    .clk(clk), .rst_n(rst_n), .en(en), .d(d[4:0]), .q(q5)
  );

  mux2_1 u_mux (
    .i0(mi0), .i1(mi1), .sel(msel), .out(mout)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m64 = '0;
    m1  = 1'b0;
    m5  = 5'h15;
  endtask

  // Drive one cycle of stimulus at the falling edge and queue what q must be after the next rising edge.
  task automatic step(input logic r, input logic e, input logic [63:0] dv);
    @(negedge clk);
    rst_n = r;
    en    = e;
    d     = dv;
    if (!r) begin
      model_reset();
    end else if (e) begin
      m64 = dv;
      m1  = dv[0:0];
      m5  = dv[4:0];
    end
    exp64_q.push_back(m64);
    exp1_q.push_back(m1);
    exp5_q.push_back(m5);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp64_q.size() > 0) check("q64", q64, exp64_q.pop_front());
    if (exp1_q.size() > 0)  check("q1", 64'(q1), 64'(exp1_q.pop_front()));
    if (exp5_q.size() > 0)  check("q5", 64'(q5), 64'(exp5_q.pop_front()));
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b1;
    en    = 1'b1;
    d     = '1;
    mi0   = 1'b0;
    mi1   = 1'b0;
    msel  = 1'b0;
    m64   = '0;
    m1    = 1'b0;
    m5    = 5'h15;

    // Asynchronous clear mid-cycle, observed before any clock edge.
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_clear_q64", q64, 64'd0);
    check("async_clear_q1", 64'(q1), 64'd0);
    check("async_clear_q5", 64'(q5), 64'h15);
    repeat (3) step(1'b0, 1'b1, '1);

    step(1'b1, 1'b1, 64'd1);
    step(1'b1, 1'b1, 64'd2);
    step(1'b1, 1'b1, 64'd3);

    step(1'b1, 1'b1, 64'hDEAD_BEEF);
    repeat (5) step(1'b1, 1'b0, 64'd7);

    step(1'b1, 1'b1, 64'd5);
    step(1'b1, 1'b0, 64'd6);
    step(1'b1, 1'b1, 64'd7);
    step(1'b1, 1'b0, 64'd8);

    step(1'b1, 1'b1, 64'h0A);
    step(1'b1, 1'b1, 64'h1F);
    step(1'b1, 1'b0, 64'h00);

    // Reset for 1.5 cycles, released at a rising edge that must not capture.
    step(1'b1, 1'b1, 64'd42);
    @(negedge clk);
    rst_n = 1'b0;
    en    = 1'b1;
    d     = 64'd9;
    model_reset();
    #1;
    check("midop_clear_q64", q64, 64'd0);
    exp64_q.push_back(m64);
    exp1_q.push_back(m1);
    exp5_q.push_back(m5);
    @(negedge clk);
    exp64_q.push_back(m64);
    exp1_q.push_back(m1);
    exp5_q.push_back(m5);
    @(posedge clk);
    #0.01;
    rst_n = 1'b1;
    step(1'b1, 1'b1, 64'd9);
    step(1'b1, 1'b0, 64'd11);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) != 0), 1'($urandom), {$urandom, $urandom});
    end
    step(1'b1, 1'b0, 64'd0);

    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      v    = 3'(k);
      mi0  = v[0];
      mi1  = v[1];
      msel = v[2];
      #1;
      check($sformatf("mux_i0%0d_i1%0d_sel%0d", v[0], v[1], v[2]), 64'(mout), 64'(v[2] ? v[1] : v[0]));
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 64'(exp64_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
